mem_block_copier: RTL and testbench
===================================

# mem_block_copier

Bus initiator that drives the data memory's single port (address, write data, write enable in; combinational read data out) to copy a block of words from one address range to another. Overlap-safe, with a running checksum. Sits beside the pipeline's MEM stage as a small DMA engine: software-visible start/len/src/dst registers feed it, and it owns the memory port while busy.

## Interface
Parameters:
- CSIZE, 31, data/address MSB index; port words are CSIZE+1 bits, matching the data memory.
- AW, 6, width of src/dst/index values.
- MEM_DEPTH, 51, number of valid memory words (addresses 0..MEM_DEPTH-1).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request; sampled only in IDLE.
- src  in  AW  first source word address.
- dst  in  AW  first destination word address.
- len  in  AW+1  word count, 0..MEM_DEPTH.
- busy  out  1  high from accepted start until done cycle, exclusive.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with done on a rejected request.
- sum  out  CSIZE+1  mod-2^(CSIZE+1) two's-complement sum of words copied.
- mem_a  out  CSIZE+1  memory address; upper bits above AW are zero.
- mem_wd  out  CSIZE+1  memory write data.
- mem_we  out  1  memory write enable.
- mem_rd  in  CSIZE+1  memory combinational read data.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE + start:
  - latch src, dst, len; clear sum.
  - If len==0, or src+len-1 > MEM_DEPTH-1, or dst+len-1 > MEM_DEPTH-1 (computed at AW+1 bits, no wrap): go to DONE with err flag set; no memory write occurs.
  - Otherwise go to READ.
- Direction, fixed at accept:
  - descending (index len-1 down to 0) when src < dst < src+len;
  - ascending (0 up to len-1) otherwise, including src==dst.
- READ: mem_a = src+idx, mem_we=0; mem_rd captured into data register at the edge; sum += mem_rd. Next state WRITE.
- WRITE: mem_a = dst+idx, mem_wd = data register, mem_we=1.
  - If last index: go to DONE.
  - Else step idx and go to READ.
- DONE: done=1 (err=1 if flagged), busy=0. Next state IDLE.
- start outside IDLE is ignored.
- sum holds its value from DONE until the next accepted start.

## Timing
- Reset values: state IDLE, busy=0, done=0, err=0, sum=0, mem_a=0, mem_wd=0, mem_we=0, idx=0.
- Reset asserted mid-transfer forces these immediately (mem_we drops asynchronously). Words already written stay written; no resume.
- Start accepted at edge 0. Valid transfer: busy high in cycles 1..2·len; done in cycle 2·len+1; IDLE in cycle 2·len+2.
- Zero-length or error: done (and err if applicable) in cycle 1, busy never high.
- Memory write commits at the edge ending each WRITE cycle. A READ of an address written earlier in the same transfer sees the new value. Direction selection prevents this from corrupting an overlapped copy.
- mem_we high only in WRITE cycles; mem_a/mem_wd driven only from registers (glitch-free to the memory).
- Back-to-back: start held high in DONE is not accepted. The next accept happens in the IDLE cycle that follows DONE.

## Structure
- Package mem_copy_pkg:
  - state enum (IDLE, READ, WRITE, DONE);
  - MEM_DEPTH default;
  - width constants for index and len.
- Sub-module mem_copy_addr_gen:
  - index counter with load, step, and direction;
  - last-index flag;
  - src+idx and dst+idx adders.
- Top holds the FSM, data register, bounds check, and sum accumulator.

## Test plan
Initial memory contents for all scenarios: mem[0..5] = -1, -2, 3, 4, -5, 1; mem[30..33] = 0.
- Disjoint ascending copy: src=0, dst=30, len=4 → mem[30..33] = -1, -2, 3, 4; sum=4; 4 mem_we pulses at addresses 30, 31, 32, 33; done in cycle 9.
- Forward-overlap copy: src=0, dst=2, len=4 → descending; mem[2..5] = -1, -2, 3, 4; mem[0..1] unchanged; sum=4.
- Backward-overlap copy: src=2, dst=0, len=4 → ascending; mem[0..3] = 3, 4, -5, 1; sum=3.
- Boundary: src=47, dst=0, len=4 → valid, last read address 50. src=48, len=4 → err and done in cycle 1, mem_we never high, sum=0. len=0 → done in cycle 1, err=1.
- Reset mid-operation: rst_n low during the third WRITE of the disjoint copy → outputs at reset values in the same cycle; mem[30..31] updated, mem[33] still 0; next start runs normally.
- start pulsed while busy, and held high through DONE → no effect on the running transfer; exactly one transfer per accepted start.

Source files
------------

// File: rtl/mem_copy_pkg.sv
// Shared types and default sizes for the block-copy DMA engine.
// Imported by the address generator and the mem_block_copier top.
package mem_copy_pkg;

  localparam int MEM_DEPTH_DEF = 51;
  localparam int AW_DEF        = 6;
  localparam int IDX_W         = AW_DEF;
  localparam int LEN_W         = AW_DEF + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Index counter and address adders for the block copier.
// Outputs the addresses for the *next* cycle, so the top can register mem_a.
module mem_copy_addr_gen
  import mem_copy_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic          desc,
  output logic          last,
  output logic [AW-1:0] rd_addr_next,
  output logic [AW-1:0] wr_addr_next
);

  logic [AW-1:0] idx, idx_d;
  logic [AW-1:0] src_q, dst_q, src_d, dst_d;
  logic [AW:0]   len_q, len_m1;
  logic          desc_q;

  assign len_m1 = len - (AW+1)'(1);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    idx_d = idx;
    if (load)
      idx_d = desc ? len_m1[AW-1:0] : '0;
    else if (step)
      idx_d = desc_q ? idx - AW'(1) : idx + AW'(1);
  end

  // On load the fresh request values bypass the registers, so the first read
  // address is ready at the accepting edge.
  assign src_d        = load ? src : src_q;
  assign dst_d        = load ? dst : dst_q;
  assign rd_addr_next = src_d + idx_d;
  assign wr_addr_next = dst_d + idx_d;

  assign last = desc_q ? (idx == '0) : ({1'b0, idx} == len_q - (AW+1)'(1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      desc_q <= 1'b0;
    end else begin
      idx <= idx_d;
      if (load) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        desc_q <= desc;
      end
    end
  end

endmodule

// File: rtl/mem_block_copier.sv
// Overlap-safe single-port memory block copier with running checksum.
// Alternates READ/WRITE cycles; direction chosen at accept to behave like memmove.
module mem_block_copier
  import mem_copy_pkg::*;
#(
  parameter int CSIZE     = 31,
  parameter int AW        = AW_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [AW-1:0]  src,
  input  logic [AW-1:0]  dst,
  input  logic [AW:0]    len,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [CSIZE:0] sum,
  output logic [CSIZE:0] mem_a,
  output logic [CSIZE:0] mem_wd,
  output logic           mem_we,
  input  logic [CSIZE:0] mem_rd
);

  localparam logic [AW+1:0] LAST_ADDR = (AW+2)'(MEM_DEPTH - 1);

  state_t        state, next_state;
  logic          accept, step, last, req_ok, desc_req, err_q;
  logic [AW+1:0] src_end, dst_end, src_lim;
  logic [AW-1:0] rd_addr_next, wr_addr_next;

  // Extra headroom bits keep the range arithmetic from wrapping.
  assign src_lim  = {2'b00, src} + {1'b0, len};
  assign src_end  = src_lim - (AW+2)'(1);
  assign dst_end  = {2'b00, dst} + {1'b0, len} - (AW+2)'(1);
  assign req_ok   = (len != '0) && (src_end <= LAST_ADDR) && (dst_end <= LAST_ADDR);
  assign desc_req = (src < dst) && ({2'b00, dst} < src_lim);

  mem_copy_addr_gen #(.AW(AW)) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (accept),
    .step         (step),
    .src          (src),
    .dst          (dst),
    .len          (len),
    .desc         (desc_req),
    .last         (last),
    .rd_addr_next (rd_addr_next),
    .wr_addr_next (wr_addr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = req_ok ? READ : DONE;
      READ:    next_state = WRITE;
      WRITE:   next_state = last ? DONE : READ;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    step   = (state == WRITE) && !last;
    busy   = (state == READ) || (state == WRITE);
    done   = (state == DONE);
    err    = (state == DONE) && err_q;
  end

  // Memory-facing outputs come straight from flops, keyed on the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      sum    <= '0;
      mem_a  <= '0;
      mem_wd <= '0;
      mem_we <= 1'b0;
    end else begin
      if (accept) begin
        err_q <= !req_ok;
        sum   <= '0;
      end else if (state == READ) begin
        sum <= sum + mem_rd;
      end
      if (state == READ) mem_wd <= mem_rd;
      case (next_state)
        READ:    mem_a <= {{(CSIZE+1-AW){1'b0}}, rd_addr_next};
        WRITE:   mem_a <= {{(CSIZE+1-AW){1'b0}}, wr_addr_next};
        default: mem_a <= '0;
      endcase
      mem_we <= (next_state == WRITE);
    end
  end

endmodule

// File: tb/tb_mem_block_copier.sv
// Self-checking bench for mem_block_copier: behavioural memory plus a
// memmove-style reference model, directed scenarios and random transfers.
module tb_mem_block_copier;

  localparam int CSIZE = 31;
  localparam int AW    = 6;
  localparam int DEPTH = 51;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [AW-1:0]  src = '0;
  logic [AW-1:0]  dst = '0;
  logic [AW:0]    len = '0;
  logic           busy, done, err, mem_we;
  logic [CSIZE:0] sum, mem_a, mem_wd, mem_rd;

  logic [31:0] mem      [0:63];
  logic [31:0] init_img [0:63];
  logic        init_go = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_block_copier #(.CSIZE(CSIZE), .AW(AW), .MEM_DEPTH(DEPTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .sum    (sum),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_we (mem_we),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[5:0]];

  always @(posedge clk) begin
    if (init_go)     mem <= init_img;
    else if (mem_we) mem[mem_a[5:0]] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_img();
    @(negedge clk);
    init_go = 1'b1;
    @(negedge clk);
    init_go = 1'b0;
  endtask

  task automatic init_plan();
    for (int i = 0; i < 64; i++) init_img[i] = $urandom;
    init_img[0] = 32'hFFFF_FFFF; init_img[1] = 32'hFFFF_FFFE;
    init_img[2] = 32'd3;         init_img[3] = 32'd4;
    init_img[4] = 32'hFFFF_FFFB; init_img[5] = 32'd1;
    for (int i = 30; i < 34; i++) init_img[i] = 32'd0;
    load_img();
  endtask

  task automatic init_random();
    for (int i = 0; i < 64; i++) init_img[i] = $urandom;
    load_img();
  endtask

  // Runs one request and compares against a memmove model of the spec rules.
  task automatic do_xfer(input int s, input int d, input int l, input string tag, input bit hold);
    logic [31:0] old [0:63];
    logic [31:0] exp_mem [0:63];
    logic [31:0] exp_sum;
    bit          valid, desc;
    int          got_wr[$], got_rd[$];
    int          busy_cnt, done_cyc, bad;
    logic        err_seen;
    logic [31:0] sum_seen;

    @(negedge clk);
    old      = mem;
    exp_mem  = mem;
    valid    = (l != 0) && (s + l - 1 <= DEPTH - 1) && (d + l - 1 <= DEPTH - 1);
    desc     = (s < d) && (d < s + l);
    exp_sum  = 32'd0;
    if (valid)
      for (int i = 0; i < l; i++) begin
        exp_sum         += old[s + i];
        exp_mem[d + i]   = old[s + i];
      end

    start = 1'b1;
    src   = AW'(s);
    dst   = AW'(d);
    len   = (AW+1)'(l);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;

    busy_cnt = 0; done_cyc = 0; err_seen = 1'b0; sum_seen = '0;
    for (int c = 1; c <= 2 * DEPTH + 4 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && mem_we)  got_wr.push_back(int'(mem_a));
      if (busy && !mem_we) got_rd.push_back(int'(mem_a));
      if (!busy && mem_we) got_wr.push_back(-1);
      if (done) begin
        done_cyc = c;
        err_seen = err;
        sum_seen = sum;
      end
    end

    check({tag, "_done_cycle"}, done_cyc, valid ? 2 * l + 1 : 1);
    check({tag, "_err"}, err_seen, !valid);
    check({tag, "_busy_cycles"}, busy_cnt, valid ? 2 * l : 0);
    check({tag, "_writes"}, got_wr.size(), valid ? l : 0);
    check({tag, "_sum"}, sum_seen, exp_sum);
    if (valid)
      for (int k = 0; k < l; k++) begin
        check({tag, "_wr_addr"}, (k < got_wr.size()) ? got_wr[k] : -1,
              desc ? d + l - 1 - k : d + k);
        check({tag, "_rd_addr"}, (k < got_rd.size()) ? got_rd[k] : -1,
              desc ? s + l - 1 - k : s + k);
      end

    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_sum_hold"}, sum, exp_sum);
    start = 1'b0;
    @(negedge clk);
    check({tag, "_no_reaccept"}, busy, 1'b0);

    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
    check({tag, "_mem_bad_words"}, bad, 0);
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_sum", sum, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_wd", mem_wd, 32'd0);
    check("rst_mem_we", mem_we, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    init_plan();
    do_xfer(0, 30, 4, "disjoint", 1'b0);
    check("disjoint_m30", mem[30], 32'hFFFF_FFFF);
    check("disjoint_m31", mem[31], 32'hFFFF_FFFE);
    check("disjoint_m32", mem[32], 32'd3);
    check("disjoint_m33", mem[33], 32'd4);
    check("disjoint_sum_const", sum, 32'd4);

    init_plan();
    do_xfer(0, 2, 4, "fwd_overlap", 1'b0);
    check("fwd_m0", mem[0], 32'hFFFF_FFFF);
    check("fwd_m1", mem[1], 32'hFFFF_FFFE);
    check("fwd_m2", mem[2], 32'hFFFF_FFFF);
    check("fwd_m3", mem[3], 32'hFFFF_FFFE);
    check("fwd_m4", mem[4], 32'd3);
    check("fwd_m5", mem[5], 32'd4);
    check("fwd_sum_const", sum, 32'd4);

    init_plan();
    do_xfer(2, 0, 4, "bwd_overlap", 1'b0);
    check("bwd_m0", mem[0], 32'd3);
    check("bwd_m1", mem[1], 32'd4);
    check("bwd_m2", mem[2], 32'hFFFF_FFFB);
    check("bwd_m3", mem[3], 32'd1);
    check("bwd_sum_const", sum, 32'd3);

    init_plan();
    do_xfer(47, 0, 4, "edge_ok", 1'b0);
    do_xfer(48, 0, 4, "edge_err", 1'b0);
    check("edge_err_sum_zero", sum, 32'd0);
    do_xfer(0, 0, 0, "len_zero", 1'b0);
    do_xfer(3, 3, 5, "same_addr", 1'b0);

    // Reset during the third WRITE of the disjoint copy.
    init_plan();
    start = 1'b1; src = AW'(0); dst = AW'(30); len = (AW+1)'(4);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_in_write", {mem_we, mem_a[5:0]}, {1'b1, 6'd32});
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_mem_we", mem_we, 1'b0);
    check("midrst_mem_a", mem_a, 32'd0);
    check("midrst_sum", sum, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_m30", mem[30], 32'hFFFF_FFFF);
    check("midrst_m31", mem[31], 32'hFFFF_FFFE);
    check("midrst_m32", mem[32], 32'd0);
    check("midrst_m33", mem[33], 32'd0);
    do_xfer(0, 30, 4, "after_rst", 1'b0);

    init_plan();
    do_xfer(0, 30, 4, "start_held", 1'b1);

    for (int t = 0; t < 25; t++) begin
      int s, d, l;
      init_random();
      s = $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) d = $urandom_range(0, 63);
      else begin
        d = s + $urandom_range(0, 8) - 4;
        if (d < 0)  d = 0;
        if (d > 63) d = 63;
      end
      l = ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH) : $urandom_range(0, 10);
      do_xfer(s, d, l, "random", t[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
